cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
- Shares one K-way cache instance between N_REQ requesters.
- Accepts requests through per-requester valid/ready handshakes and picks among them round-robin.
- Sequences the cache's single-cycle read and multi-cycle write/evict strobes, then returns a one-cycle response to the owning requester.
- Sits between client blocks and the cache; it is the only driver of the cache's read/write/addr/value inputs.

Parameters:
- ADDR_WIDTH, 8, cache address width.
- LINE_WIDTH, 32, cache line width.
- N_REQ, 2, number of requesters (2..8).
- WRITE_TIMEOUT, 8, maximum cycles in WRITE before the request is aborted with an error; must be >= 2*K+2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_write  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_WIDTH  flattened addresses; requester i is slice i.
- req_wdata  in  N_REQ*LINE_WIDTH  flattened write data.
- req_ready  out  N_REQ  one-hot accept.
- resp_valid  out  N_REQ  one-hot, one-cycle response strobe.
- resp_hit  out  1  read: line present; write: completed.
- resp_data  out  LINE_WIDTH  read data; 0 for writes and misses.
- resp_err  out  1  write timeout.
- busy  out  1  high whenever state != IDLE.
- cache_addr  out  ADDR_WIDTH  address to the cache.
- cache_wdata  out  LINE_WIDTH  write data to the cache.
- cache_read  out  1  read strobe.
- cache_write  out  1  write strobe.
- cache_hit  in  1  registered hit from the cache.
- cache_rdata  in  LINE_WIDTH  registered read data from the cache.

Behaviour:
- Reset:
  - State goes to IDLE and the RR pointer to 0.
  - req_ready, resp_valid, cache_read, cache_write, resp_hit, resp_err and busy go to 0.
  - resp_data, cache_addr and cache_wdata go to 0.
- Reset mid-operation:
  - The in-flight request is dropped and no response is issued; strobes deassert in the cycle after reset is sampled.
  - The cache itself has no reset. A cache left mid-evict completes on the next write using the new address.
- Handshake:
  - A requester holds valid, write, addr and wdata stable until it sees ready.
  - A transfer happens on valid && ready. Responses have no backpressure.
- Arbitration:
  - In IDLE, req_ready is combinational and one-hot: it selects the first asserted req_valid at or after the RR pointer, searching circularly.
  - On accept, the pointer becomes (granted+1) mod N_REQ.
  - The arbiter latches id, op, addr and wdata from the granted requester.
  - req_ready is always 0 outside IDLE.
- States:
  - IDLE: on accept, go to READ or WRITE.
  - READ:
    - cache_read=1 for exactly one cycle, then go to READ_WAIT.
  - READ_WAIT:
    - Sample cache_hit and cache_rdata into resp_hit and resp_data.
    - resp_data is 0 if cache_hit=0.
    - Go to RESP.
  - WRITE:
    - cache_write = 1 && !(wcnt != 0 && cache_hit). This is combinational on the registered cache_hit.
    - The first WRITE cycle (wcnt=0) ignores cache_hit, which may be stale from an earlier read.
    - wcnt increments each cycle.
    - If wcnt != 0 && cache_hit: set resp_hit=1 and go to RESP.
    - Else if wcnt == WRITE_TIMEOUT-1: set resp_err=1, resp_hit=0, and go to RESP.
  - RESP:
    - resp_valid[id]=1 for one cycle, with resp_hit, resp_data and resp_err valid in that cycle.
    - Go to IDLE. No new grant is issued in this cycle.
- Latency, counted from the accept cycle (cycle 0):
  - Read: response at cycle 3.
  - Write hit: cache_write high in cycle 1 only, response at cycle 3.
  - Write miss: response at cycle 2 + the number of cache evict cycles, bounded by WRITE_TIMEOUT+1.
- Throughput: at most one request in flight; the next accept happens no earlier than the cycle after RESP.
- cache_addr and cache_wdata come from the latched request and are held stable from the accept cycle until RESP.
- Simultaneous valids: exactly one requester is granted per IDLE cycle; the others keep valid asserted.
- N_REQ=1: the pointer is constant 0.

Decomposition:
- Package cache_ctrl_pkg holds:
  - the state enum (IDLE, READ, READ_WAIT, WRITE, RESP);
  - the op encoding (OP_READ=0, OP_WRITE=1);
  - the function clog2_min1 for the id and pointer widths.
- Sub-module rr_arbiter (parameter N): inputs req[N], advance, clock and reset; outputs a one-hot grant[N] and a grant index. It owns the RR pointer.

Test Plan:
- Reset then read: requester 0 reads addr 0x10 after a prior write of 0xDEADBEEF. Required: resp_valid=01 at cycle 3 with resp_hit=1, resp_data=0xDEADBEEF; cache_read high in exactly one cycle.
- Read miss: read addr 0x55 that was never written. Required: resp_hit=0 and resp_data=0 at cycle 3.
- Write-hit then write-miss with eviction (K=2):
  - Fill addrs 0x01 and 0x02.
  - Write 0x01 again: cache_write high for exactly 1 cycle; response at cycle 3 with hit=1, err=0.
  - Write 0x03: eviction occurs. Subsequent reads show 0x03 present and exactly one of 0x01/0x02 evicted.
- Round-robin: both requesters hold valid continuously for 4 requests each. Required grant order 0,1,0,1…; no requester waits more than one transaction; ready never high outside IDLE.
- Timeout: cache model holds cache_hit=0. Required: after WRITE_TIMEOUT=8 write cycles, resp_err=1, resp_hit=0, cache_write deasserted, then back in IDLE.
- Reset mid-write: assert reset during WRITE cycle 2. Required: no resp_valid, cache_write=0 and busy=0 in the cycle after reset is sampled, and the next request is granted to requester 0.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache port arbiter: FSM states, op encoding, width helper.
// Latency: n/a (types only).
// Backpressure: n/a.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        READ_WAIT,
        WRITE,
        RESP
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Index width that never collapses to zero bits, so N=1 still gets a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or after the pointer.
// Latency: grant is combinational; pointer moves on the clock after advance.
// Backpressure: none; the caller decides when a grant is consumed via advance.
module rr_arbiter
    import cache_ctrl_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = clog2_min1(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] sel;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        sel       = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            sel = IW'((int'(ptr) + k) % N);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache between N_REQ requesters: RR grant, read/write strobe sequencing, one-cycle response.
// Latency: read and write-hit respond 3 cycles after accept; write-miss 2+evict cycles, capped at WRITE_TIMEOUT+1.
// Backpressure: one request in flight, req_ready only in IDLE; responses cannot be stalled.
module cache_port_arbiter
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int LINE_WIDTH    = 32,
    parameter int N_REQ         = 2,
    parameter int WRITE_TIMEOUT = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_write,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*LINE_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            resp_valid,
    output logic                        resp_hit,
    output logic [LINE_WIDTH-1:0]       resp_data,
    output logic                        resp_err,
    output logic                        busy,
    output logic [ADDR_WIDTH-1:0]       cache_addr,
    output logic [LINE_WIDTH-1:0]       cache_wdata,
    output logic                        cache_read,
    output logic                        cache_write,
    input  logic                        cache_hit,
    input  logic [LINE_WIDTH-1:0]       cache_rdata
);

    localparam int IW = clog2_min1(N_REQ);
    localparam int CW = clog2_min1(WRITE_TIMEOUT);

    state_t                state_q, state_d;
    logic [N_REQ-1:0]      grant;
    logic [IW-1:0]         grant_idx;
    logic [IW-1:0]         id_q;
    op_t                   op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] data_q;
    logic [CW-1:0]         wcnt_q;
    logic                  hit_q;
    logic                  err_q;
    logic                  accept;
    logic                  write_done;
    logic                  write_expired;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready     = (state_q == IDLE && !reset) ? grant : '0;
    assign accept        = |req_ready;
    // The first WRITE cycle sees cache_hit left over from whatever the cache did before.
    assign write_done    = (wcnt_q != '0) && cache_hit;
    assign write_expired = (wcnt_q == CW'(WRITE_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cache_read  = 1'b0;
        cache_write = 1'b0;
        resp_valid  = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = req_write[grant_idx] ? WRITE : READ;
                end
            end
            READ: begin
                cache_read = 1'b1;
                state_d    = READ_WAIT;
            end
            READ_WAIT: begin
                state_d = RESP;
            end
            WRITE: begin
                cache_write = !write_done;
                if (write_done || write_expired) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid[id_q] = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            wcnt_q  <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q    <= grant_idx;
                        op_q    <= req_write[grant_idx] ? OP_WRITE : OP_READ;
                        addr_q  <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q <= req_wdata[grant_idx*LINE_WIDTH +: LINE_WIDTH];
                        data_q  <= '0;
                        wcnt_q  <= '0;
                        hit_q   <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                READ_WAIT: begin
                    hit_q  <= cache_hit;
                    data_q <= cache_hit ? cache_rdata : '0;
                end
                WRITE: begin
                    wcnt_q <= wcnt_q + 1'b1;
                    if (write_done) begin
                        hit_q <= 1'b1;
                    end else if (write_expired) begin
                        err_q <= 1'b1;
                        hit_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_hit    = hit_q;
    assign resp_err    = err_q;
    assign resp_data   = (op_q == OP_READ) ? data_q : '0;
    assign busy        = (state_q != IDLE);
    assign cache_addr  = addr_q;
    assign cache_wdata = wdata_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: 2-way cache model, directed scenarios, then randomized traffic.
// A transaction-level model predicts grant, strobe windows and response for every cycle.
module tb_cache_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int LW = 32;
    localparam int WT = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*LW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, resp_valid;
    logic            resp_hit, resp_err, busy, cache_read, cache_write;
    logic [LW-1:0]   resp_data, cache_wdata;
    logic [AW-1:0]   cache_addr;
    logic            cache_hit = 1'b0;
    logic [LW-1:0]   cache_rdata = '0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    cache_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .N_REQ(N), .WRITE_TIMEOUT(WT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_read(cache_read), .cache_write(cache_write), .cache_hit(cache_hit), .cache_rdata(cache_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- 2-way fully associative cache model (no reset) ----------------
    bit            cv[2] = '{default: 1'b0};
    logic [AW-1:0] ct[2];
    logic [LW-1:0] cd[2];
    int            ev_cnt = 0;
    int            victim = 0;
    int            ev_cycles = 1;
    bit            stuck = 1'b0;

    function automatic int lookup(input logic [AW-1:0] a);
        for (int k = 0; k < 2; k++) if (cv[k] && ct[k] == a) return k;
        return -1;
    endfunction

    always @(posedge clock) begin
        int w, f;
        w = lookup(cache_addr);
        if (cache_read === 1'b1) begin
            cache_hit <= (w >= 0);
            if (w >= 0) cache_rdata <= cd[w];
            else        cache_rdata <= $urandom;
        end else if (cache_write === 1'b1) begin
            if (w >= 0) begin
                cd[w] <= cache_wdata; cache_hit <= 1'b1; ev_cnt <= 0;
            end else if (stuck) begin
                cache_hit <= 1'b0;
            end else if (ev_cnt + 1 >= ev_cycles) begin
                f = !cv[0] ? 0 : (!cv[1] ? 1 : victim);
                if (cv[0] && cv[1]) victim <= victim ^ 1;
                cv[f] <= 1'b1; ct[f] <= cache_addr; cd[f] <= cache_wdata;
                cache_hit <= 1'b1; ev_cnt <= 0;
            end else begin
                ev_cnt <= ev_cnt + 1; cache_hit <= 1'b0;
            end
        end
    end

    // ---------------- transaction-level reference and per-cycle compare ----------------
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (r == '0 && v[(p + k) % N]) r[(p + k) % N] = 1'b1;
        end
        return r;
    endfunction

    int            cyc = 0;
    bit            m_busy = 1'b0;
    int            m_ptr = 0, m_id = 0, m_acc = 0, m_rc = 0, m_wcyc = 0;
    bit            m_wr = 1'b0, m_hit = 1'b0, m_err = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_data = '0, m_edata = '0;

    always @(negedge clock) begin
        logic [N-1:0] er;
        int c, w;
        if (reset) begin
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (m_busy) begin
            c = cyc - m_acc;
            check("busy", busy, 1);
            check("ready_while_busy", req_ready, 0);
            check("cache_read", cache_read, (!m_wr && c == 1));
            check("cache_write", cache_write, (m_wr && c >= 1 && c <= m_wcyc));
            check("cache_addr", cache_addr, m_addr);
            if (m_wr) check("cache_wdata", cache_wdata, m_data);
            check("resp_valid", resp_valid, (c == m_rc) ? (64'd1 << m_id) : 64'd0);
            if (c == m_rc) begin
                check("resp_hit", resp_hit, m_hit);
                check("resp_err", resp_err, m_err);
                check("resp_data", resp_data, m_edata);
                m_busy = 1'b0;
            end
        end else begin
            er = rr_pick(req_valid, m_ptr);
            check("busy_idle", busy, 0);
            check("req_ready", req_ready, er);
            check("resp_valid_idle", resp_valid, 0);
            check("strobes_idle", {cache_read, cache_write}, 0);
            if (er != '0) begin
                m_id   = er[1] ? 1 : 0;
                m_wr   = req_write[m_id];
                m_addr = req_addr[m_id*AW +: AW];
                m_data = req_wdata[m_id*LW +: LW];
                m_acc  = cyc;
                m_ptr  = (m_id + 1) % N;
                m_busy = 1'b1;
                w      = lookup(m_addr);
                m_err  = 1'b0;
                m_edata = '0;
                if (!m_wr) begin
                    m_rc = 3; m_wcyc = 0; m_hit = (w >= 0);
                    if (w >= 0) m_edata = cd[w];
                end else if (w >= 0) begin
                    m_rc = 3; m_wcyc = 1; m_hit = 1'b1;
                end else if (stuck) begin
                    m_rc = WT + 1; m_wcyc = WT; m_hit = 1'b0; m_err = 1'b1;
                end else begin
                    m_rc = 2 + ev_cycles; m_wcyc = ev_cycles; m_hit = 1'b1;
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input int id, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                          output int lat, output bit hit, output bit err, output logic [LW-1:0] data,
                          output int rd_n, output int wr_n);
        bit got;
        @(posedge clock); #1;
        req_valid[id] = 1'b1; req_write[id] = wr;
        req_addr[id*AW +: AW] = a; req_wdata[id*LW +: LW] = d;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clock);
            got = req_ready[id];
        end
        check("accept_seen", got, 1);
        @(posedge clock); #1;
        req_valid[id] = 1'b0;
        lat = 0; hit = 0; err = 0; data = '0; rd_n = 0; wr_n = 0; got = 1'b0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clock);
            rd_n += int'(cache_read);
            wr_n += int'(cache_write);
            if (resp_valid[id]) begin
                got = 1'b1; lat = n; hit = resp_hit; err = resp_err; data = resp_data;
            end
        end
        check("resp_seen", got, 1);
    endtask

    int            lat, rn, wn, n_acc, j, h1, h2;
    bit            hit, err, gen, done;
    logic [LW-1:0] data;
    logic [N-1:0]  g, acc;
    int            order[8];
    int            cnt[N];

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_resp_hit", resp_hit, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_cache_addr", cache_addr, 0);
        check("rst_cache_wdata", cache_wdata, 0);
        check("rst_busy", busy, 0);

        // Write then read back through requester 0.
        ev_cycles = 1;
        do_req(0, 1, 8'h10, 32'hDEADBEEF, lat, hit, err, data, rn, wn);
        check("w10_lat", lat, 3);
        do_req(0, 0, 8'h10, 32'h0, lat, hit, err, data, rn, wn);
        check("r10_lat", lat, 3);
        check("r10_hit", hit, 1);
        check("r10_data", data, 32'hDEADBEEF);
        check("r10_read_cycles", rn, 1);
        do_req(1, 0, 8'h55, 32'h0, lat, hit, err, data, rn, wn);
        check("r55_lat", lat, 3);
        check("r55_hit", hit, 0);
        check("r55_data", data, 0);

        // Fill both ways, re-write a resident line, then force an eviction.
        do_req(0, 1, 8'h01, 32'h0101_0101, lat, hit, err, data, rn, wn);
        do_req(1, 1, 8'h02, 32'h0202_0202, lat, hit, err, data, rn, wn);
        do_req(0, 1, 8'h01, 32'h1111_0001, lat, hit, err, data, rn, wn);
        check("whit_lat", lat, 3);
        check("whit_write_cycles", wn, 1);
        check("whit_hit", hit, 1);
        check("whit_err", err, 0);
        ev_cycles = 3;
        do_req(1, 1, 8'h03, 32'h3333_0003, lat, hit, err, data, rn, wn);
        check("wmiss_lat", lat, 5);
        check("wmiss_write_cycles", wn, 3);
        check("wmiss_hit", hit, 1);
        ev_cycles = 1;
        do_req(0, 0, 8'h03, 32'h0, lat, hit, err, data, rn, wn);
        check("r03_hit", hit, 1);
        check("r03_data", data, 32'h3333_0003);
        do_req(1, 0, 8'h01, 32'h0, lat, hit, err, data, rn, wn);
        h1 = int'(hit);
        do_req(0, 0, 8'h02, 32'h0, lat, hit, err, data, rn, wn);
        h2 = int'(hit);
        check("one_of_01_02_evicted", h1 + h2, 1);

        // Write timeout with a cache that never reports hit.
        stuck = 1'b1;
        do_req(0, 1, 8'h77, 32'h7777_7777, lat, hit, err, data, rn, wn);
        check("to_lat", lat, WT + 1);
        check("to_err", err, 1);
        check("to_hit", hit, 0);
        check("to_write_cycles", wn, WT);
        @(negedge clock);
        check("to_idle_busy", busy, 0);
        check("to_idle_write", cache_write, 0);

        // Reset during the second WRITE cycle.
        @(posedge clock); #1;
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0 +: AW] = 8'h66;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clock);
            done = req_ready[0];
        end
        check("rstw_accept", done, 1);
        @(posedge clock); #1 req_valid[0] = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("rstw_write", cache_write, 0);
        check("rstw_busy", busy, 0);
        j = 0;
        for (int n = 0; n < 12; n++) begin
            if (resp_valid != '0) j++;
            @(negedge clock);
        end
        check("rstw_no_resp", j, 0);
        stuck = 1'b0;

        // Both requesters hold valid for four reads each.
        @(posedge clock); #1;
        req_write = '0;
        req_addr[0 +: AW] = 8'h03; req_addr[AW +: AW] = 8'h02;
        req_valid = '1;
        n_acc = 0; cnt[0] = 0; cnt[1] = 0;
        for (int t = 0; t < 200 && n_acc < 8; t++) begin
            @(negedge clock);
            g = req_ready;
            if (g != '0) begin
                j = g[1] ? 1 : 0;
                order[n_acc] = j;
                n_acc++;
                cnt[j]++;
            end
            @(posedge clock); #1;
            if (g != '0 && cnt[j] >= 4) req_valid[j] = 1'b0;
        end
        check("rr_count", n_acc, 8);
        for (int k = 0; k < n_acc; k++) check("rr_order", order[k], k % 2);

        // Randomized traffic in rounds; cache behaviour changes only while drained.
        for (int r = 0; r < 12; r++) begin
            done = 1'b0;
            for (int t = 0; t < 300 && !done; t++) begin
                @(negedge clock);
                done = (req_valid == '0) && !busy;
            end
            check("drain", done, 1);
            stuck     = ($urandom_range(0, 4) == 0);
            ev_cycles = $urandom_range(1, 4);
            for (int t = 0; t < 80; t++) begin
                @(negedge clock);
                acc = req_valid & req_ready;
                gen = (t < 60);
                @(posedge clock); #1;
                for (int i = 0; i < N; i++) begin
                    if (acc[i]) req_valid[i] = 1'b0;
                    if (!req_valid[i] && gen && $urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_write[i] = 1'($urandom_range(0, 1));
                        req_addr[i*AW +: AW] = AW'($urandom_range(0, 5));
                        req_wdata[i*LW +: LW] = $urandom;
                    end
                end
            end
            for (int t = 0; t < 300 && req_valid != '0; t++) begin
                @(negedge clock);
                acc = req_valid & req_ready;
                @(posedge clock); #1;
                req_valid = req_valid & ~acc;
            end
        end
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clock);
            done = (req_valid == '0) && !busy;
        end
        check("final_drain", done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        fails++;
        $display("FAIL watchdog: got no finish, want finish before %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
